div_radix2: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
//  The stage raises start_i when alucontrolE is EXE_DIV_OP or EXE_DIVU_OP.

---
 rtl/div_radix2_if.sv | 24 ++
 rtl/div_radix2.sv | 144 ++++++++++++++
 tb/tb_div_radix2.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/div_radix2_if.sv
// Handshake bundle between the execute stage and the radix-2 divider.
// The stage drives the request side; the divider returns result, ready and stall.
interface div_radix2_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 signed_i;
    logic                 annul_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );
endinterface

// File: rtl/div_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle.
// Returns {remainder, quotient} and stalls the pipeline while an operation is in flight.
//
// state    | meaning
// S_IDLE   | waiting for a request; launch cycle already asserts busy
// S_BYZERO | divisor was zero, staging an all-zero result
// S_ON     | iterating, one quotient bit per cycle
// S_END    | result valid, ready high for this single cycle
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        resetn,
    div_radix2_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [2*WIDTH-1:0]   r_result;

    logic                 w_launch;
    logic                 w_last;
    logic                 w_busy;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_trial;
    logic [WIDTH-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]     w_quo_nxt;
    logic [WIDTH-1:0]     w_q_fin;
    logic [WIDTH-1:0]     w_r_fin;

    assign w_abs1 = (bus.signed_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign w_abs2 = (bus.signed_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    assign w_launch = (r_state == S_IDLE) && bus.start_i && !bus.annul_i
                      && (bus.opdata2_i != '0);
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // The extra top bit of the trial difference is the borrow.
    always_comb begin
        w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
        w_trial   = w_rem_sh - {1'b0, r_div};
        w_rem_nxt = w_rem_sh[WIDTH-1:0];
        w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH]) begin
            w_rem_nxt = w_trial[WIDTH-1:0];
            w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
        end
        w_q_fin = r_neg_q ? -w_quo_nxt : w_quo_nxt;
        w_r_fin = r_neg_r ? -w_rem_nxt : w_rem_nxt;
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_busy = 1'b1;
                    w_next = (bus.opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                w_busy = 1'b1;
                w_next = S_END;
            end
            S_ON: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = S_END;
                end
            end
            S_END: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (bus.annul_i) begin
            w_next = S_IDLE;
            w_busy = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else begin
            if (w_launch) begin
                r_cnt   <= '0;
                r_rem   <= '0;
                r_quo   <= w_abs1;
                r_div   <= w_abs2;
                r_neg_q <= bus.signed_i && (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
                r_neg_r <= bus.signed_i && bus.opdata1_i[WIDTH-1];
            end else if (r_state == S_ON) begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end
            // Result only moves on the edge into S_END, so an annulled divide leaves it intact.
            if (r_state == S_ON && w_next == S_END) begin
                r_result <= {w_r_fin, w_q_fin};
            end else if (r_state == S_BYZERO && w_next == S_END) begin
                r_result <= '0;
            end
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = (r_state == S_END);
    assign bus.busy_o   = w_busy;

endmodule

// File: tb/tb_div_radix2.sv
// Self-checking bench for div_radix2: directed divides with literal expectations,
// plus a per-cycle timeline model of busy/ready/result derived from plain arithmetic.
module tb_div_radix2;
    localparam int W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    div_radix2_if #(.WIDTH(W)) bus ();

    div_radix2 #(.WIDTH(W)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Timeline model: a launch predicts the ready cycle and the result.
    logic        m_active = 1'b0;
    int          m_done   = 0;
    logic [63:0] m_pend   = '0;
    logic [63:0] m_res    = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            m_active = 1'b0;
            m_res    = '0;
            chk("rst_ready", {63'd0, bus.ready_o}, 64'd0);
            chk("rst_result", bus.result_o, m_res);
            chk("rst_busy", {63'd0, bus.busy_o}, {63'd0, bus.start_i & ~bus.annul_i});
        end else begin
            if (!m_active && bus.start_i && !bus.annul_i) begin
                m_active = 1'b1;
                m_done   = cyc + ((bus.opdata2_i == '0) ? 2 : W + 1);
                m_pend   = model(bus.opdata1_i, bus.opdata2_i, bus.signed_i);
            end
            if (m_active && cyc == m_done) m_res = m_pend;
            chk("busy", {63'd0, bus.busy_o}, {63'd0, m_active && !bus.annul_i && cyc < m_done});
            chk("ready", {63'd0, bus.ready_o}, {63'd0, m_active && cyc == m_done});
            chk("result", bus.result_o, m_res);
            if (m_active && (cyc == m_done || bus.annul_i)) m_active = 1'b0;
        end
    end

    task automatic wait_ready(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 45 && !seen; i++) begin
            @(negedge clk);
            if (bus.ready_o) seen = 1'b1;
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int lat, input string name);
        int t0;
        bit seen;
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.signed_i  = s;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        t0 = cyc;
        @(posedge clk); #1;
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom | 32'd1;
        bus.signed_i  = ~s;
        wait_ready(seen);
        chk({name, "_seen"}, {63'd0, seen}, 64'd1);
        chk({name, "_lat"}, 64'(cyc - t0), 64'(lat));
        chk({name, "_res"}, bus.result_o, exp);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        bit  seen;
        bus.start_i   = 1'b0;
        bus.signed_i  = 1'b0;
        bus.annul_i   = 1'b0;
        bus.opdata1_i = '0;
        bus.opdata2_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_result_lit", bus.result_o, 64'd0);
        chk("reset_ready_lit", {63'd0, bus.ready_o}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        do_div(32'd5, 32'd0, 1'b1, 64'd0, 2, "div5_by0");
        do_div(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, "divu100_7");
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        do_div(32'hFFFF_FFF9, 32'd2, 1'b0, {32'd1, 32'h7FFF_FFFC}, 33, "divu_fff9_2");
        do_div(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, 33, "div_7_m2");
        do_div(32'h8000_0000, 32'd1, 1'b1, {32'd0, 32'h8000_0000}, 33, "div_min_1");
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 33, "div_min_m1");

        // Annul mid-operation, then relaunch immediately
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.signed_i  = 1'b0;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        t0 = cyc;
        repeat (10) @(posedge clk);
        #1 bus.annul_i = 1'b1;
        @(negedge clk);
        chk("annul_busy", {63'd0, bus.busy_o}, 64'd0);
        @(posedge clk); #1;
        bus.annul_i   = 1'b0;
        bus.opdata1_i = 32'd1000;
        bus.opdata2_i = 32'd10;
        @(negedge clk);
        chk("annul_hold_res", bus.result_o, {32'd0, 32'h8000_0000});
        chk("annul_no_ready", {63'd0, bus.ready_o}, 64'd0);
        wait_ready(seen);
        chk("relaunch_seen", {63'd0, seen}, 64'd1);
        chk("relaunch_lat", 64'(cyc - t0), 64'd44);
        chk("relaunch_res", bus.result_o, {32'd0, 32'd100});
        @(posedge clk); #1;
        bus.start_i = 1'b0;

        // Back-to-back with start held across END, then reset mid-divide
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        t0 = cyc;
        wait_ready(seen);
        chk("b2b1_lat", 64'(cyc - t0), 64'd33);
        chk("b2b1_res", bus.result_o, {32'd0, 32'd3});
        @(posedge clk); #1;
        bus.opdata1_i = 32'd10;
        bus.opdata2_i = 32'd4;
        wait_ready(seen);
        chk("b2b2_lat", 64'(cyc - t0), 64'd67);
        chk("b2b2_res", bus.result_o, {32'd2, 32'd2});
        @(posedge clk); #1;
        bus.opdata1_i = 32'd50;
        bus.opdata2_i = 32'd5;
        repeat (20) @(posedge clk);
        #1;
        resetn      = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("midrst_result", bus.result_o, 64'd0);
        chk("midrst_busy", {63'd0, bus.busy_o}, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        wait_ready(seen);
        chk("midrst_no_ready", {63'd0, seen}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
